hwpe_job_ctrl_slave: RTL and testbench

- TCDM-style responder for the HWPE control path in the cluster tile.
- Terminates the 32-bit peripheral request stream produced by the AXI-to-TCDM bridge.
- Holds a two-slot double-buffered job register context. Hands committed jobs to the engine one at a time.
- Returns per-core completion events that drive the cluster mxip lines.

---
 rtl/hwpe_job_ctrl_slave.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hwpe_job_ctrl_slave.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_job_ctrl_slave.sv
`default_nettype none
// ============================================================================
//  Module      : hwpe_job_ctrl_slave
//  Description : TCDM-style peripheral responder for the HWPE control path.
//                Two double-buffered job contexts (acquire / program / trigger),
//                in-order dispatch to the engine, and per-core completion events.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwpe_job_ctrl_slave #(
    parameter int NrCores     = 8,
    parameter int NumJobRegs  = 8,
    parameter int CoreIdWidth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         q_valid_i,
    output logic                         q_ready_o,
    input  logic [31:0]                  q_addr_i,
    input  logic                         q_write_i,
    input  logic [31:0]                  q_data_i,
    input  logic [3:0]                   q_strb_i,
    input  logic [CoreIdWidth-1:0]       q_user_i,
    output logic                         p_valid_o,
    output logic [31:0]                  p_data_o,
    output logic                         job_start_o,
    output logic [32*NumJobRegs-1:0]     job_regs_o,
    input  logic                         job_busy_i,
    input  logic                         job_done_i,
    output logic [NrCores-1:0]           evt_o
);

    localparam int         RegIdxW  = (NumJobRegs > 1) ? $clog2(NumJobRegs) : 1;
    localparam logic [4:0] NUM_REGS = 5'(NumJobRegs);

    // Word offsets (byte address bits [7:2]) of the control registers
    localparam logic [5:0] W_TRIGGER  = 6'h00;
    localparam logic [5:0] W_ACQUIRE  = 6'h01;
    localparam logic [5:0] W_FINISHED = 6'h02;
    localparam logic [5:0] W_STATUS   = 6'h03;
    localparam logic [5:0] W_RUNNING  = 6'h04;
    localparam logic [5:0] W_CLEAR    = 6'h05;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_ACQ    = 2'd1,
        SLOT_QUEUED = 2'd2,
        SLOT_RUN    = 2'd3
    } slot_e;

    typedef logic [NumJobRegs-1:0][31:0] ctx_t;

    // Per-slot context
    slot_e                  st_q    [2];
    slot_e                  st_d    [2];
    logic [CoreIdWidth-1:0] owner_q [2];
    logic [CoreIdWidth-1:0] owner_d [2];
    logic [7:0]             jid_q   [2];
    logic [7:0]             jid_d   [2];
    ctx_t                   regs_q  [2];
    ctx_t                   regs_d  [2];

    // Global state; older_q names the earlier-triggered slot when both are queued
    logic               older_q,  older_d;
    logic [7:0]         jcnt_q,   jcnt_d;
    logic [31:0]        fin_q,    fin_d;
    ctx_t               jregs_q,  jregs_d;
    logic               start_q,  start_d;
    logic               pvalid_q, pvalid_d;
    logic [31:0]        pdata_q,  pdata_d;
    logic [NrCores-1:0] evt_q,    evt_d;
    logic               clr_q,    clr_d;

    // Request decode
    logic               w_req;
    logic [5:0]         w_word;
    logic               w_in_win;
    logic [RegIdxW-1:0] w_ridx;
    logic               w_unused_addr;

    assign w_req         = q_valid_i & q_ready_o;
    assign w_word        = q_addr_i[7:2];
    assign w_in_win      = (w_word[5:4] == 2'b01) && ({1'b0, w_word[3:0]} < NUM_REGS);
    assign w_ridx        = w_word[RegIdxW-1:0];
    assign w_unused_addr = ^{q_addr_i[31:8], q_addr_i[1:0]};

    // Per-slot status flags
    logic [1:0] w_own;
    logic [1:0] w_free;
    logic [1:0] w_run;
    logic [1:0] w_queued;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        assign w_own[s]    = (st_q[s] == SLOT_ACQ) && (owner_q[s] == q_user_i);
        assign w_free[s]   = (st_q[s] == SLOT_FREE);
        assign w_run[s]    = (st_q[s] == SLOT_RUN);
        assign w_queued[s] = (st_q[s] == SLOT_QUEUED);
    end

    // Lowest-index selection; at most one slot can ever be running
    logic       w_own_idx;
    logic       w_free_idx;
    logic       w_run_idx;
    logic [1:0] w_nq;

    assign w_own_idx  = ~w_own[0];
    assign w_free_idx = ~w_free[0];
    assign w_run_idx  = w_run[1];
    assign w_nq       = {1'b0, w_queued[0]} + {1'b0, w_queued[1]};

    // Read data mux, evaluated on the pre-update state
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            W_ACQUIRE:  w_rdata = (|w_free) ? {24'd0, jcnt_q} : 32'hFFFF_FFFF;
            W_FINISHED: w_rdata = fin_q;
            W_STATUS:   w_rdata = {29'd0, w_nq, job_busy_i | (|w_run)};
            W_RUNNING:  w_rdata = (|w_run) ? {24'd0, jid_q[w_run_idx]} : 32'hFFFF_FFFF;
            default: begin
                if (w_in_win && (|w_own)) begin
                    w_rdata = regs_q[w_own_idx][w_ridx];
                end
            end
        endcase
    end

    // Next-state: request side effects, completion, dispatch, then soft clear on top
    logic w_q0;
    logic w_q1;
    logic w_any_run;
    logic w_pick;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            st_d[s]    = st_q[s];
            owner_d[s] = owner_q[s];
            jid_d[s]   = jid_q[s];
            regs_d[s]  = regs_q[s];
        end
        older_d   = older_q;
        jcnt_d    = jcnt_q;
        fin_d     = fin_q;
        jregs_d   = jregs_q;
        start_d   = 1'b0;
        pvalid_d  = w_req;
        pdata_d   = '0;
        evt_d     = '0;
        clr_d     = 1'b0;
        w_q0      = 1'b0;
        w_q1      = 1'b0;
        w_any_run = 1'b0;
        w_pick    = 1'b0;

        if (w_req && !q_write_i) begin
            pdata_d = w_rdata;
        end

        if (w_req) begin
            if (!q_write_i && (w_word == W_ACQUIRE) && (|w_free)) begin
                st_d[w_free_idx]    = SLOT_ACQ;
                owner_d[w_free_idx] = q_user_i;
                jid_d[w_free_idx]   = jcnt_q;
                jcnt_d              = jcnt_q + 8'd1;
            end
            if (q_write_i && (w_word == W_TRIGGER) && (|w_own)) begin
                st_d[w_own_idx] = SLOT_QUEUED;
                if (st_q[~w_own_idx] == SLOT_QUEUED) begin
                    older_d = ~w_own_idx;
                end
            end
            if (q_write_i && w_in_win && (|w_own)) begin
                for (int b = 0; b < 4; b++) begin
                    if (q_strb_i[b]) begin
                        regs_d[w_own_idx][w_ridx][8*b +: 8] = q_data_i[8*b +: 8];
                    end
                end
            end
        end

        if (job_done_i && (|w_run)) begin
            st_d[w_run_idx] = SLOT_FREE;
            if (fin_q != 32'hFFFF_FFFF) begin
                fin_d = fin_q + 32'd1;
            end
            evt_d = NrCores'(1) << owner_q[w_run_idx];
        end

        // Dispatch looks at the post-done state so a freed engine restarts at once
        w_q0      = (st_d[0] == SLOT_QUEUED);
        w_q1      = (st_d[1] == SLOT_QUEUED);
        w_any_run = (st_d[0] == SLOT_RUN) || (st_d[1] == SLOT_RUN);
        w_pick    = (w_q0 && w_q1) ? older_d : ~w_q0;
        if (!w_any_run && !job_busy_i && (w_q0 || w_q1)) begin
            st_d[w_pick] = SLOT_RUN;
            jregs_d      = regs_q[w_pick];
            start_d      = 1'b1;
        end

        if (w_req && q_write_i && (w_word == W_CLEAR)) begin
            for (int s = 0; s < 2; s++) begin
                st_d[s]    = SLOT_FREE;
                owner_d[s] = '0;
                jid_d[s]   = '0;
                regs_d[s]  = '0;
            end
            older_d = 1'b0;
            jcnt_d  = '0;
            fin_d   = '0;
            jregs_d = '0;
            start_d = 1'b0;
            evt_d   = '0;
            clr_d   = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]    <= SLOT_FREE;
                owner_q[s] <= '0;
                jid_q[s]   <= '0;
                regs_q[s]  <= '0;
            end
            older_q  <= 1'b0;
            jcnt_q   <= '0;
            fin_q    <= '0;
            jregs_q  <= '0;
            start_q  <= 1'b0;
            pvalid_q <= 1'b0;
            pdata_q  <= '0;
            evt_q    <= '0;
            clr_q    <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                st_q[s]    <= st_d[s];
                owner_q[s] <= owner_d[s];
                jid_q[s]   <= jid_d[s];
                regs_q[s]  <= regs_d[s];
            end
            older_q  <= older_d;
            jcnt_q   <= jcnt_d;
            fin_q    <= fin_d;
            jregs_q  <= jregs_d;
            start_q  <= start_d;
            pvalid_q <= pvalid_d;
            pdata_q  <= pdata_d;
            evt_q    <= evt_d;
            clr_q    <= clr_d;
        end
    end

    assign q_ready_o   = ~clr_q;
    assign p_valid_o   = pvalid_q;
    assign p_data_o    = pdata_q;
    assign job_start_o = start_q;
    assign job_regs_o  = jregs_q;
    assign evt_o       = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_job_ctrl_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwpe_job_ctrl_slave
//  Description : Self-checking bench for hwpe_job_ctrl_slave; directed steps
//                followed by random traffic against a slot/queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_job_ctrl_slave;

    localparam int NC = 8;
    localparam int NR = 8;
    localparam int CW = 3;

    localparam int FREE = 0;
    localparam int ACQ  = 1;
    localparam int QUE  = 2;
    localparam int RUN  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            q_valid = 1'b0;
    logic            q_ready;
    logic [31:0]     q_addr = '0;
    logic            q_write = 1'b0;
    logic [31:0]     q_data = '0;
    logic [3:0]      q_strb = '0;
    logic [CW-1:0]   q_user = '0;
    logic            p_valid;
    logic [31:0]     p_data;
    logic            start;
    logic [32*NR-1:0] jregs;
    logic            busy = 1'b0;
    logic            done = 1'b0;
    logic [NC-1:0]   evt;

    always #5 clk = ~clk;

    hwpe_job_ctrl_slave #(
        .NrCores    (NC),
        .NumJobRegs (NR),
        .CoreIdWidth(CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .q_valid_i  (q_valid),
        .q_ready_o  (q_ready),
        .q_addr_i   (q_addr),
        .q_write_i  (q_write),
        .q_data_i   (q_data),
        .q_strb_i   (q_strb),
        .q_user_i   (q_user),
        .p_valid_o  (p_valid),
        .p_data_o   (p_data),
        .job_start_o(start),
        .job_regs_o (jregs),
        .job_busy_i (busy),
        .job_done_i (done),
        .evt_o      (evt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: slot table plus an explicit FIFO of triggered slots
    int              m_st  [2];
    int              m_own [2];
    int              m_jid [2];
    logic [31:0]     m_regs[2][NR];
    int              m_q[$];
    int              m_run;
    int              m_cnt;
    logic [31:0]     m_fin;
    logic            m_ready;
    logic [32*NR-1:0] m_jregs;

    logic            e_pvalid;
    logic [31:0]     e_pdata;
    logic            e_start;
    logic [NC-1:0]   e_evt;

    logic [7:0]      a;
    logic [31:0]     tmp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_st[s]  = FREE;
            m_own[s] = 0;
            m_jid[s] = 0;
            for (int r = 0; r < NR; r++) m_regs[s][r] = '0;
        end
        m_q.delete();
        m_run   = -1;
        m_cnt   = 0;
        m_fin   = '0;
        m_jregs = '0;
    endtask

    function automatic int m_owned(input int user);
        for (int s = 0; s < 2; s++) begin
            if (m_st[s] == ACQ && m_own[s] == user) return s;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input int w, input int user);
        int o;
        int nq;
        logic [31:0] r;
        o  = m_owned(user);
        nq = 0;
        r  = '0;
        for (int s = 0; s < 2; s++) if (m_st[s] == QUE) nq++;
        if (w == 1) begin
            r = 32'hFFFF_FFFF;
            if (m_st[0] == FREE || m_st[1] == FREE) r = m_cnt;
        end else if (w == 2) begin
            r = m_fin;
        end else if (w == 3) begin
            r = nq * 2 + ((busy || m_run >= 0) ? 1 : 0);
        end else if (w == 4) begin
            r = (m_run >= 0) ? m_jid[m_run] : 32'hFFFF_FFFF;
        end else if (w >= 16 && w < 16 + NR && o >= 0) begin
            r = m_regs[o][w-16];
        end
        return r;
    endfunction

    // One clock: predict from current inputs, advance, compare every output
    task automatic step();
        logic req;
        int w;
        int o;
        int fs;
        req      = q_valid && m_ready;
        w        = int'(q_addr[7:2]);
        e_pvalid = req;
        e_pdata  = '0;
        e_start  = 1'b0;
        e_evt    = '0;
        if (req && !q_write) e_pdata = m_read(w, int'(q_user));
        if (req && q_write && w == 5) begin
            model_clear();
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b1;
            o = m_owned(int'(q_user));
            if (req && !q_write && w == 1) begin
                fs = -1;
                for (int s = 1; s >= 0; s--) if (m_st[s] == FREE) fs = s;
                if (fs >= 0) begin
                    m_st[fs]  = ACQ;
                    m_own[fs] = int'(q_user);
                    m_jid[fs] = m_cnt;
                    m_cnt     = (m_cnt + 1) % 256;
                end
            end
            if (req && q_write && w == 0 && o >= 0) begin
                m_st[o] = QUE;
                m_q.push_back(o);
            end
            if (req && q_write && w >= 16 && w < 16 + NR && o >= 0) begin
                for (int b = 0; b < 4; b++)
                    if (q_strb[b]) m_regs[o][w-16][8*b +: 8] = q_data[8*b +: 8];
            end
            if (done && m_run >= 0) begin
                m_st[m_run] = FREE;
                if (m_fin != 32'hFFFF_FFFF) m_fin = m_fin + 1;
                e_evt[m_own[m_run]] = 1'b1;
                m_run = -1;
            end
            if (m_run < 0 && !busy && m_q.size() > 0) begin
                m_run       = m_q.pop_front();
                m_st[m_run] = RUN;
                e_start     = 1'b1;
                for (int r = 0; r < NR; r++) m_jregs[32*r +: 32] = m_regs[m_run][r];
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("p_valid", p_valid, e_pvalid);
        chk("p_data", p_data, e_pdata);
        chk("job_start", start, e_start);
        chk("job_regs", jregs, m_jregs);
        chk("evt", evt, e_evt);
        chk("q_ready", q_ready, m_ready);
    endtask

    task automatic rd(input logic [7:0] ad, input int u);
        q_valid = 1'b1; q_write = 1'b0; q_addr = {24'd0, ad};
        q_data = '0; q_strb = '0; q_user = u[CW-1:0];
        step();
        q_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] s, input int u);
        q_valid = 1'b1; q_write = 1'b1; q_addr = {24'd0, ad};
        q_data = d; q_strb = s; q_user = u[CW-1:0];
        step();
        q_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        model_clear();
        m_ready = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", q_ready, 1'b1);
        chk("rst_pvalid", p_valid, 1'b0);
        chk("rst_pdata", p_data, 32'd0);
        chk("rst_start", start, 1'b0);
        chk("rst_regs", jregs, '0);
        chk("rst_evt", evt, '0);
        rst_n = 1'b1;

        // Basic job from core 2
        rd(8'h04, 2);
        chk("t1_acq_id", p_data, 32'd0);
        wr(8'h40, 32'hDEAD_BEEF, 4'hF, 2);
        wr(8'h00, 32'd0, 4'hF, 2);
        chk("t1_start", start, 1'b1);
        chk("t1_reg0", jregs[31:0], 32'hDEAD_BEEF);
        pulse_done();
        chk("t1_evt", evt, 8'h04);
        rd(8'h08, 2);
        chk("t1_finished", p_data, 32'd1);

        // Three acquires on a fresh context
        wr(8'h14, 32'd0, 4'hF, 0);
        chk("t2_clr_ready", q_ready, 1'b0);
        step();
        rd(8'h04, 0);
        chk("t2_acq0", p_data, 32'd0);
        rd(8'h04, 1);
        chk("t2_acq1", p_data, 32'd1);
        rd(8'h04, 2);
        chk("t2_acq_full", p_data, 32'hFFFF_FFFF);
        rd(8'h0C, 0);
        chk("t2_status", p_data, 32'd0);

        // Both slots queued behind a busy engine, then in-order dispatch
        busy = 1'b1;
        wr(8'h00, 32'd0, 4'hF, 0);
        wr(8'h00, 32'd0, 4'hF, 1);
        rd(8'h0C, 0);
        chk("t3_nqueued", p_data[2:1], 2'd2);
        busy = 1'b0;
        step();
        chk("t3_start_a", start, 1'b1);
        busy = 1'b1;
        rd(8'h10, 0);
        chk("t3_running_a", p_data, 32'd0);
        busy = 1'b0;
        pulse_done();
        chk("t3_start_b", start, 1'b1);
        chk("t3_evt_a", evt, 8'h01);
        rd(8'h10, 0);
        chk("t3_running_b", p_data, 32'd1);
        pulse_done();
        chk("t3_evt_b", evt, 8'h02);

        // Byte strobes and ownership
        rd(8'h04, 3);
        wr(8'h44, 32'h1122_3344, 4'hF, 3);
        wr(8'h44, 32'h0000_AB00, 4'b0010, 3);
        rd(8'h44, 3);
        chk("t4_strobe", p_data, 32'h1122_AB44);
        wr(8'h44, 32'hFFFF_FFFF, 4'hF, 5);
        rd(8'h44, 3);
        chk("t4_nonowner_wr", p_data, 32'h1122_AB44);
        rd(8'h44, 5);
        chk("t4_nonowner_rd", p_data, 32'd0);

        // Soft clear while a job runs
        wr(8'h00, 32'd0, 4'hF, 3);
        chk("t5_start", start, 1'b1);
        wr(8'h14, 32'd0, 4'hF, 0);
        chk("t5_clr_ready", q_ready, 1'b0);
        step();
        chk("t5_ready_back", q_ready, 1'b1);
        rd(8'h0C, 0);
        chk("t5_status", p_data, 32'd0);
        pulse_done();
        chk("t5_evt", evt, 8'h00);
        rd(8'h08, 0);
        chk("t5_finished", p_data, 32'd0);

        // Job ID wrap after 256 jobs
        for (int i = 0; i < 256; i++) begin
            rd(8'h04, 0);
            chk("t6_id", p_data, i);
            wr(8'h00, 32'd0, 4'hF, 0);
            pulse_done();
        end
        rd(8'h04, 0);
        chk("t6_wrap", p_data, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 8'h00;
                1:       a = 8'h04;
                2:       a = 8'h08;
                3:       a = 8'h0C;
                4:       a = 8'h10;
                5:       a = ($urandom_range(0, 63) == 0) ? 8'h14 : 8'h04;
                6, 7:    a = 8'(64 + 4 * $urandom_range(0, NR - 1));
                8:       a = 8'(64 + 4 * $urandom_range(0, NR + 1));
                default: a = 8'($urandom_range(0, 255));
            endcase
            tmp     = $urandom;
            q_addr  = {tmp[31:8], a};
            q_valid = ($urandom_range(0, 2) != 0);
            q_write = 1'($urandom_range(0, 1));
            q_user  = CW'($urandom_range(0, 3));
            q_strb  = 4'($urandom_range(0, 15));
            q_data  = $urandom;
            busy    = ($urandom_range(0, 3) == 0);
            done    = ($urandom_range(0, 4) == 0);
            step();
        end
        q_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        step();

        // Asynchronous reset while a response is pending
        q_valid = 1'b1; q_write = 1'b0; q_addr = 32'h0000_0008; q_user = '0;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        chk("rst_resp_pending", p_valid, m_ready);
        rst_n = 1'b0;
        #1;
        chk("rst_async_pvalid", p_valid, 1'b0);
        chk("rst_async_pdata", p_data, 32'd0);
        chk("rst_async_start", start, 1'b0);
        chk("rst_async_regs", jregs, '0);
        chk("rst_async_evt", evt, '0);
        chk("rst_async_ready", q_ready, 1'b1);
        model_clear();
        m_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'h04, 1);
        chk("post_rst_acq", p_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
